gs_div_issue: RTL and testbench

- Initiator-side sequencer for the Goldschmidt divider (gs_div).
- Accepts division requests over a valid/ready handshake, parks and launches the divider through its active-high start/reset input, and waits for done after a blanking window.
- Captures the quotient and returns it with a status code and tag over a valid/ready response channel.
- Screens divide-by-zero locally without launching the divider, and bounds every launch with a timeout.

---
 rtl/gs_div_issue_if.sv | 26 ++
 rtl/gs_div_issue.sv | 161 ++++++++++++++++
 tb/tb_gs_div_issue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_div_issue_if.sv
// Request and response channels between a division client and the gs_div_issue sequencer.
interface gs_div_issue_if #(
    parameter int W     = 64,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_n;
    logic [W-1:0]     req_d;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_q;
    logic [1:0]       rsp_status;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_n, req_d, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_status, rsp_tag
    );

    modport slave (
        input  req_valid, req_n, req_d, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_status, rsp_tag
    );
endinterface

// File: rtl/gs_div_issue.sv
// Initiator-side sequencer for the Goldschmidt divider: parks and launches gs_div,
// ignores stale done during a blanking window, bounds each launch and returns a tagged result.
module gs_div_issue #(
    parameter int W         = 64,
    parameter int TAG_W     = 4,
    parameter int START_CYC = 2,
    parameter int BLANK_CYC = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    gs_div_issue_if.slave bus,
    output logic          div_start,
    output logic [W-1:0]  div_n,
    output logic [W-1:0]  div_d,
    input  logic [W-1:0]  div_q,
    input  logic          div_done,
    output logic          busy
);
    localparam int CNT_W = $clog2(TIMEOUT + START_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM  = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] STAT_OK  = 2'b00;
    localparam logic [1:0] STAT_DBZ = 2'b01;
    localparam logic [1:0] STAT_TMO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t           state_r,      state_s;
    logic [CNT_W-1:0] cnt_r,        cnt_s;
    logic [W-1:0]     rsp_q_r,      rsp_q_s;
    logic [1:0]       rsp_status_r, rsp_status_s;
    logic [TAG_W-1:0] rsp_tag_r,    rsp_tag_s;
    logic [W-1:0]     div_n_r,      div_n_s;
    logic [W-1:0]     div_d_r,      div_d_s;
    logic             req_ready_r,  req_ready_s;
    logic             rsp_valid_r,  rsp_valid_s;
    logic             div_start_r,  div_start_s;
    logic             busy_r,       busy_s;

    // Next state, counter and result/operand capture
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        rsp_q_s      = rsp_q_r;
        rsp_status_s = rsp_status_r;
        rsp_tag_s    = rsp_tag_r;
        div_n_s      = div_n_r;
        div_d_s      = div_d_r;
        case (state_r)
            S_IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    rsp_tag_s = bus.req_tag;
                    if (bus.req_d == {W{1'b0}}) begin
                        // Divide-by-zero is answered locally; the divider stays parked
                        rsp_q_s      = {W{1'b1}};
                        rsp_status_s = STAT_DBZ;
                        state_s      = S_RESP;
                    end else begin
                        div_n_s = bus.req_n;
                        div_d_s = bus.req_d;
                        cnt_s   = CNT_ZERO;
                        state_s = S_START;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_r == START_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = S_WAIT;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = S_START;
                end
            end
            S_WAIT: begin
                cnt_s = cnt_r + CNT_ONE;
                // A done level left over from the last run is masked until the blank window ends
                if (div_done && (cnt_r >= BLANK_LIM)) begin
                    rsp_q_s      = div_q;
                    rsp_status_s = STAT_OK;
                    state_s      = S_RESP;
                end else if (cnt_r == TMO_LAST) begin
                    rsp_q_s      = {W{1'b0}};
                    rsp_status_s = STAT_TMO;
                    state_s      = S_RESP;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output flags decoded from the upcoming state so they are registered with it
    always_comb begin
        req_ready_s = (state_s == S_IDLE);
        rsp_valid_s = (state_s == S_RESP);
        div_start_s = (state_s != S_WAIT);
        busy_s      = (state_s != S_IDLE);
    end

    // State, counter and registered outputs; reset parks the divider at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            cnt_r        <= CNT_ZERO;
            rsp_q_r      <= {W{1'b0}};
            rsp_status_r <= STAT_OK;
            rsp_tag_r    <= {TAG_W{1'b0}};
            div_n_r      <= {W{1'b0}};
            div_d_r      <= {W{1'b0}};
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            div_start_r  <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            rsp_q_r      <= rsp_q_s;
            rsp_status_r <= rsp_status_s;
            rsp_tag_r    <= rsp_tag_s;
            div_n_r      <= div_n_s;
            div_d_r      <= div_d_s;
            req_ready_r  <= req_ready_s;
            rsp_valid_r  <= rsp_valid_s;
            div_start_r  <= div_start_s;
            busy_r       <= busy_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_q      = rsp_q_r;
    assign bus.rsp_status = rsp_status_r;
    assign bus.rsp_tag    = rsp_tag_r;
    assign div_start      = div_start_r;
    assign div_n          = div_n_r;
    assign div_d          = div_d_r;
    assign busy           = busy_r;
endmodule

// File: tb/tb_gs_div_issue.sv
// Randomized bench for gs_div_issue with a behavioural divider and a rule-level response model.
module tb_gs_div_issue;
    localparam int W         = 64;
    localparam int TAG_W     = 4;
    localparam int START_CYC = 2;
    localparam int BLANK_CYC = 2;
    localparam int TIMEOUT   = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         div_start, div_done, busy;
    logic [W-1:0] div_n, div_d, div_q;

    int vectors = 0;
    int errors  = 0;
    int dm_delay = 1;
    bit dm_stale = 1'b0;
    int dm_rel   = -1;

    typedef struct {
        bit accepted; bit got; bit released; bit ops_ok; bit stable; bit blocked;
        bit post_ok; bit dstart_resp;
        int acc_wait; int start_hi; int acc_lat; int rel_lat;
        logic [W-1:0] q; logic [1:0] status; logic [TAG_W-1:0] tag;
    } obs_t;

    gs_div_issue_if #(.W(W), .TAG_W(TAG_W)) bus ();

    gs_div_issue #(
        .W(W), .TAG_W(TAG_W), .START_CYC(START_CYC), .BLANK_CYC(BLANK_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .div_start(div_start), .div_n(div_n), .div_d(div_d),
        .div_q(div_q), .div_done(div_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // 32.32 fixed-point quotient
    function automatic logic [W-1:0] fxdiv(input logic [W-1:0] n, input logic [W-1:0] d);
        logic [2*W-1:0] num, quo;
        num = {{W{1'b0}}, n} << (W / 2);
        quo = num / {{W{1'b0}}, d};
        return quo[W-1:0];
    endfunction

    // Cycle after release at which rsp_valid appears, from the done pattern and the rules
    function automatic int exp_rel(input int delay, input bit stale, output logic [1:0] st);
        st = 2'b10;
        for (int k = BLANK_CYC; k < TIMEOUT; k++) begin
            if ((k == 0 && stale) || (delay > 0 && k >= delay)) begin
                st = 2'b00;
                return k + 1;
            end
        end
        return TIMEOUT;
    endfunction

    // Divider model: done level relative to release, optional stale done held across release
    initial begin
        div_done = 1'b0;
        div_q    = {W{1'b0}};
        forever begin
            @(negedge clk);
            if (div_start) dm_rel = -1;
            else dm_rel++;
            if (dm_rel <= 0) div_done = dm_stale;
            else div_done = (dm_delay > 0) && (dm_rel >= dm_delay);
            if (div_done && div_d != {W{1'b0}}) div_q = fxdiv(div_n, div_d);
            else div_q = {$urandom(), $urandom()};
        end
    end

    task automatic exec_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic [TAG_W-1:0] tag,
                           input int delay, input bit stale, input int bp, output obs_t o);
        int rel;
        o = '{default: 0};
        o.ops_ok = 1'b1; o.stable = 1'b1; o.blocked = 1'b1; o.acc_lat = -1; o.rel_lat = -1;
        dm_delay = delay;
        dm_stale = stale;
        bus.req_valid = 1'b1; bus.req_n = n; bus.req_d = d; bus.req_tag = tag;
        for (int i = 0; i < 50 && !o.accepted; i++) begin
            if (bus.req_ready) o.accepted = 1'b1;
            else o.acc_wait++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0; bus.req_n = {$urandom(), $urandom()}; bus.req_d = {$urandom(), $urandom()};
        if (!o.accepted) return;
        rel = 0;
        for (int k = 1; k <= 200 && !o.got; k++) begin
            if (o.released) rel++;
            else if (!div_start) o.released = 1'b1;
            else if (!bus.rsp_valid) o.start_hi++;
            if (bus.rsp_valid) begin
                o.got = 1'b1; o.acc_lat = k; o.rel_lat = o.released ? rel : -1;
                o.q = bus.rsp_q; o.status = bus.rsp_status; o.tag = bus.rsp_tag;
                o.dstart_resp = div_start;
            end else begin
                if (div_n !== n || div_d !== d) o.ops_ok = 1'b0;
                @(negedge clk);
            end
        end
        if (!o.got) return;
        for (int b = 0; b < bp; b++) begin
            bus.req_valid = 1'b1; bus.req_d = {W{1'b1}}; bus.req_tag = ~tag;
            @(negedge clk);
            if (bus.rsp_q !== o.q || bus.rsp_status !== o.status || bus.rsp_tag !== o.tag) o.stable = 1'b0;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || div_start !== 1'b1) o.blocked = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        o.post_ok = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        logic [201:0] act, exp;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        act = {bus.req_ready, bus.rsp_valid, bus.rsp_q, bus.rsp_status, bus.rsp_tag, div_start, div_n, div_d, busy};
        exp = {1'b1, 1'b0, 64'd0, 2'd0, 4'd0, 1'b1, 64'd0, 64'd0, 1'b0};
        vectors++;
        if (act !== exp) begin errors++; $display("FAIL reset_values act=%h exp=%h", act, exp); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.req_ready, busy, div_start} !== 3'b101) begin
            errors++; $display("FAIL reset_release act=%b exp=101", {bus.req_ready, busy, div_start});
        end
    endtask

    task automatic test_basic();
        obs_t o;
        exec_op(64'h0000000A_00000000, 64'h00000002_00000000, 4'd3, 30, 1'b0, 0, o);
        vectors++; if (!o.got) begin errors++; $display("FAIL basic_resp got=%0b exp=1", o.got); end
        vectors++; if (o.start_hi != START_CYC) begin errors++; $display("FAIL basic_start_cyc act=%0d exp=%0d", o.start_hi, START_CYC); end
        vectors++; if (o.rel_lat != 31) begin errors++; $display("FAIL basic_latency act=%0d exp=31", o.rel_lat); end
        vectors++; if (o.q !== 64'h00000005_00000000) begin errors++; $display("FAIL basic_q act=%h exp=0000000500000000", o.q); end
        vectors++;
        if (o.status !== 2'b00 || o.tag !== 4'd3) begin
            errors++; $display("FAIL basic_status_tag act=%b/%0d exp=00/3", o.status, o.tag);
        end
        vectors++;
        if (!(o.ops_ok && o.dstart_resp && o.post_ok)) begin
            errors++; $display("FAIL basic_ctrl act=%b%b%b exp=111", o.ops_ok, o.dstart_resp, o.post_ok);
        end
    endtask

    task automatic test_stale_done();
        obs_t o;
        exec_op(64'h00000009_00000000, 64'h00000003_00000000, 4'd5, 20, 1'b1, 0, o);
        vectors++; if (o.rel_lat != 21) begin errors++; $display("FAIL stale_latency act=%0d exp=21", o.rel_lat); end
        vectors++;
        if (o.q !== 64'h00000003_00000000 || o.status !== 2'b00) begin
            errors++; $display("FAIL stale_result act=%h/%b exp=0000000300000000/00", o.q, o.status);
        end
    endtask

    task automatic test_div_zero();
        obs_t o;
        exec_op(64'h12345678_9ABCDEF0, 64'd0, 4'd7, 5, 1'b0, 0, o);
        vectors++; if (o.acc_lat != 1) begin errors++; $display("FAIL dbz_latency act=%0d exp=1", o.acc_lat); end
        vectors++;
        if (o.q !== {W{1'b1}} || o.status !== 2'b01 || o.tag !== 4'd7) begin
            errors++; $display("FAIL dbz_result act=%h/%b/%0d exp=ffffffffffffffff/01/7", o.q, o.status, o.tag);
        end
        vectors++;
        if (o.released || o.start_hi != 0 || !o.dstart_resp) begin
            errors++; $display("FAIL dbz_no_launch act=%b/%0d exp=0/0", o.released, o.start_hi);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exec_op(64'h00000001_00000000, 64'h00000004_00000000, 4'd2, -1, 1'b0, 0, o);
        vectors++; if (o.rel_lat != TIMEOUT) begin errors++; $display("FAIL tmo_latency act=%0d exp=%0d", o.rel_lat, TIMEOUT); end
        vectors++;
        if (o.q !== {W{1'b0}} || o.status !== 2'b10 || !o.dstart_resp) begin
            errors++; $display("FAIL tmo_result act=%h/%b/%b exp=0/10/1", o.q, o.status, o.dstart_resp);
        end
    endtask

    task automatic test_done_vs_timeout();
        obs_t o;
        exec_op(64'h00000006_00000000, 64'h00000002_00000000, 4'd4, TIMEOUT - 1, 1'b0, 0, o);
        vectors++;
        if (o.status !== 2'b00 || o.q !== 64'h00000003_00000000 || o.rel_lat != TIMEOUT) begin
            errors++; $display("FAIL edge_done_wins act=%b/%h/%0d exp=00/0000000300000000/%0d", o.status, o.q, o.rel_lat, TIMEOUT);
        end
        exec_op(64'h00000006_00000000, 64'h00000002_00000000, 4'd4, TIMEOUT, 1'b0, 0, o);
        vectors++;
        if (o.status !== 2'b10 || o.q !== {W{1'b0}}) begin
            errors++; $display("FAIL edge_late_done act=%b/%h exp=10/0", o.status, o.q);
        end
        exec_op(64'h00000006_00000000, 64'h00000002_00000000, 4'd4, 1, 1'b0, 0, o);
        vectors++;
        if (o.rel_lat != BLANK_CYC + 1) begin
            errors++; $display("FAIL edge_blank_end act=%0d exp=%0d", o.rel_lat, BLANK_CYC + 1);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exec_op(64'h00000010_00000000, 64'h00000004_00000000, 4'd11, 8, 1'b0, 10, o);
        vectors++;
        if (!o.stable || !o.blocked) begin errors++; $display("FAIL bp_hold act=%b%b exp=11", o.stable, o.blocked); end
        vectors++;
        if (!o.post_ok || o.tag !== 4'd11 || o.q !== 64'h00000004_00000000) begin
            errors++; $display("FAIL bp_release act=%b/%0d/%h exp=1/11/0000000400000000", o.post_ok, o.tag, o.q);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exec_op(64'h00000002_00000000, 64'h00000001_00000000, 4'd1, 3, 1'b0, 0, o);
        exec_op(64'h00000008_00000000, 64'h00000002_00000000, 4'd6, 3, 1'b0, 0, o);
        vectors++;
        if (o.acc_wait != 0 || o.q !== 64'h00000004_00000000 || o.tag !== 4'd6) begin
            errors++; $display("FAIL b2b act=%0d/%h/%0d exp=0/0000000400000000/6", o.acc_wait, o.q, o.tag);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [W-1:0] n, d, eq;
        logic [TAG_W-1:0] tag;
        logic [1:0] est;
        int erel, delay, bp;
        bit stale;
        for (int i = 0; i < 24; i++) begin
            n = {$urandom(), $urandom()};
            d = ($urandom_range(0, 5) == 0) ? {W{1'b0}} : {$urandom_range(0, 15), $urandom()};
            tag = TAG_W'($urandom_range(0, 15));
            delay = $urandom_range(1, 70);
            stale = 1'($urandom_range(0, 1));
            bp = $urandom_range(0, 3);
            exec_op(n, d, tag, delay, stale, bp, o);
            if (d == {W{1'b0}}) begin
                est = 2'b01; eq = {W{1'b1}}; erel = -1;
            end else begin
                erel = exp_rel(delay, stale, est);
                eq = (est == 2'b00) ? fxdiv(n, d) : {W{1'b0}};
            end
            vectors++; if (!o.got) begin errors++; $display("FAIL rand_resp[%0d] got=0 exp=1", i); end
            vectors++; if (o.q !== eq) begin errors++; $display("FAIL rand_q[%0d] act=%h exp=%h", i, o.q, eq); end
            vectors++;
            if (o.status !== est || o.tag !== tag) begin
                errors++; $display("FAIL rand_status_tag[%0d] act=%b/%0d exp=%b/%0d", i, o.status, o.tag, est, tag);
            end
            vectors++;
            if (o.rel_lat != erel || o.start_hi != ((d == {W{1'b0}}) ? 0 : START_CYC)) begin
                errors++; $display("FAIL rand_timing[%0d] act=%0d/%0d exp=%0d", i, o.rel_lat, o.start_hi, erel);
            end
            vectors++;
            if (!(o.ops_ok && o.stable && o.blocked && o.post_ok && o.dstart_resp)) begin
                errors++; $display("FAIL rand_ctrl[%0d] act=%b%b%b%b%b exp=11111", i,
                                   o.ops_ok, o.stable, o.blocked, o.post_ok, o.dstart_resp);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit acc, rel_seen;
        int seen_valid;
        acc = 1'b0; rel_seen = 1'b0; seen_valid = 0;
        dm_delay = 30; dm_stale = 1'b0;
        bus.req_valid = 1'b1; bus.req_n = {$urandom(), $urandom()};
        bus.req_d = {$urandom_range(1, 15), $urandom()}; bus.req_tag = 4'd9;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (bus.req_ready) acc = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !rel_seen; i++) begin
            if (!div_start) rel_seen = 1'b1;
            else @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (!acc || !rel_seen) begin errors++; $display("FAIL rst_setup act=%b%b exp=11", acc, rel_seen); end
        vectors++;
        if ({div_start, bus.rsp_valid, busy, bus.req_ready} !== 4'b1001) begin
            errors++; $display("FAIL rst_abort act=%b exp=1001", {div_start, bus.rsp_valid, busy, bus.req_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_valid++;
        end
        vectors++; if (seen_valid != 0) begin errors++; $display("FAIL rst_no_resp act=%0d exp=0", seen_valid); end
        vectors++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_idle act=%b%b exp=10", bus.req_ready, busy);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_n = {W{1'b0}}; bus.req_d = {W{1'b0}};
        bus.req_tag = {TAG_W{1'b0}}; bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_stale_done();
        test_div_zero();
        test_timeout();
        test_done_vs_timeout();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
